alphamission_snd_post: RTL and testbench

Sound post-processor between the YM3526 FM core output (`snd`/`sample`) and the platform audio mixer. On each sample strobe (55.556 kHz) it captures the 16-bit signed FM sample and optionally removes DC. It then applies an 8-bit volume gain with saturation and mute. The result is presented as a registered, duplicated L/R pair with its own strobe.

---
 rtl/alphamission_snd_pkg.sv | 28 ++
 rtl/alphamission_snd_post_dcblock.sv | 37 +++
 rtl/alphamission_snd_post.sv | 146 ++++++++++++++
 tb/tb_alphamission_snd_post.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alphamission_snd_pkg.sv
// Shared types, constants and the 16-bit saturation helper for the
// Alpha Mission sound post-processor.
package alphamission_snd_pkg;

    localparam int         SND_W      = 16;
    localparam logic [7:0] GAIN_UNITY = 8'h40;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_DCB  = 3'd1,
        ST_GAIN = 3'd2,
        ST_SAT  = 3'd3,
        ST_OUT  = 3'd4
    } snd_post_st_e;

    function automatic logic signed [SND_W-1:0] sat16(input logic signed [31:0] v);
        logic signed [SND_W-1:0] r;
        if (v > 32'sd32767) begin
            r = 16'sh7fff;
        end else if (v < -32'sd32768) begin
            r = 16'sh8000;
        end else begin
            r = v[SND_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/alphamission_snd_post_dcblock.sv
// One-pole DC blocker: Y is Q16.8 in 26 bits, x1 is the previous input.
// Advances one step per en_i pulse; f_o is the saturated output of that step.
module snd_dcblock
    import alphamission_snd_pkg::*;
#(
    parameter int DCB_SHIFT = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en_i,
    input  logic signed [SND_W-1:0] x_i,
    output logic signed [SND_W-1:0] f_o
);

    logic signed [25:0]      y_q, y_d;
    logic signed [SND_W-1:0] x1_q;
    logic signed [25:0]      diff;
    logic signed [31:0]      y_ext;

    always_comb begin
        diff  = $signed({{10{x_i[15]}}, x_i}) - $signed({{10{x1_q[15]}}, x1_q});
        y_d   = (diff <<< 8) + y_q - (y_q >>> DCB_SHIFT);
        y_ext = {{6{y_d[25]}}, y_d};
        f_o   = sat16(y_ext >>> 8);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q  <= '0;
            x1_q <= '0;
        end else if (en_i) begin
            y_q  <= y_d;
            x1_q <= x_i;
        end
    end

endmodule

// File: rtl/alphamission_snd_post.sv
// FM sound post-processor: capture, optional DC block, Q2.6 gain, saturation, mute.
// Define ALPHAMISSION_SND_DCBLOCK_EN to build the DC blocker into the DCB stage.
module alphamission_snd_post
    import alphamission_snd_pkg::*;
#(
    parameter int GAIN_FRAC = 6,
    parameter int DCB_SHIFT = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [SND_W-1:0] snd_in,
    input  logic                    sample_in,
    input  logic [7:0]              gain,
    input  logic                    mute,
    output logic signed [SND_W-1:0] snd_l,
    output logic signed [SND_W-1:0] snd_r,
    output logic                    sample_out,
    output logic                    busy,
    output logic [7:0]              clip_cnt
);

    if (GAIN_FRAC < 1 || GAIN_FRAC > 8 || DCB_SHIFT < 1 || DCB_SHIFT > 16) begin : g_param_check
        $error("alphamission_snd_post: GAIN_FRAC or DCB_SHIFT out of range");
    end

    snd_post_st_e state_q, state_d;
    logic         start;

    logic signed [SND_W-1:0] x_q, f_q, f_dcb, snd_q;
    logic [7:0]              g_q, clip_q;
    logic                    m_q;
    logic signed [24:0]      p_q, p_d, f_ext, g_ext;
    logic signed [31:0]      p_ext, q_ext;
    logic                    clip;

    // One-deep pending slot; the newest arrival while busy overwrites it.
    logic                    pend_v_q;
    logic signed [SND_W-1:0] pend_x_q;
    logic [7:0]              pend_g_q;
    logic                    pend_m_q;

`ifdef ALPHAMISSION_SND_DCBLOCK_EN
    snd_dcblock #(
        .DCB_SHIFT (DCB_SHIFT)
    ) u_dcblock (
        .clk  (clk),
        .rst  (rst),
        .en_i (state_q == ST_DCB),
        .x_i  (x_q),
        .f_o  (f_dcb)
    );
`else
    assign f_dcb = x_q;
`endif

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sample_in || pend_v_q) begin
                    start   = 1'b1;
                    state_d = ST_DCB;
                end
            end
            ST_DCB:  state_d = ST_GAIN;
            ST_GAIN: state_d = ST_SAT;
            ST_SAT:  state_d = ST_OUT;
            ST_OUT:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        f_ext = {{9{f_q[15]}}, f_q};
        g_ext = {17'd0, g_q};
        p_d   = f_ext * g_ext;
        p_ext = {{7{p_q[24]}}, p_q};
        q_ext = p_ext >>> GAIN_FRAC;
        clip  = (q_ext > 32'sd32767) || (q_ext < -32'sd32768);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q      <= '0;
            g_q      <= '0;
            m_q      <= 1'b0;
            f_q      <= '0;
            p_q      <= '0;
            snd_q    <= '0;
            clip_q   <= '0;
            pend_v_q <= 1'b0;
            pend_x_q <= '0;
            pend_g_q <= '0;
            pend_m_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && sample_in) begin
                        x_q <= snd_in;
                        g_q <= gain;
                        m_q <= mute;
                    end else if (start) begin
                        x_q <= pend_x_q;
                        g_q <= pend_g_q;
                        m_q <= pend_m_q;
                    end
                end
                ST_DCB:  f_q <= f_dcb;
                ST_GAIN: p_q <= p_d;
                ST_SAT: begin
                    // Output register loads here so it is already valid during OUT.
                    snd_q <= m_q ? '0 : sat16(q_ext);
                    if (!m_q && clip && clip_q != 8'hFF) begin
                        clip_q <= clip_q + 8'd1;
                    end
                end
                default: ;
            endcase

            if (sample_in && state_q != ST_IDLE) begin
                pend_v_q <= 1'b1;
                pend_x_q <= snd_in;
                pend_g_q <= gain;
                pend_m_q <= mute;
            end else if (start) begin
                pend_v_q <= 1'b0;
            end
        end
    end

    assign snd_l      = snd_q;
    assign snd_r      = snd_q;
    assign sample_out = (state_q == ST_OUT);
    assign busy       = (state_q != ST_IDLE);
    assign clip_cnt   = clip_q;

endmodule

// File: tb/tb_alphamission_snd_post.sv
// Self-checking bench for alphamission_snd_post; honours ALPHAMISSION_SND_DCBLOCK_EN.
`timescale 1ns/1ps
module tb_alphamission_snd_post;
  import alphamission_snd_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [15:0] snd_in;
  logic               sample_in;
  logic [7:0]         gain;
  logic               mute;
  logic signed [15:0] snd_l, snd_r;
  logic               sample_out, busy;
  logic [7:0]         clip_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [15:0] exp_q[$];
  int          exp_cyc_q[$];
  logic [15:0] last_exp;
  logic [15:0] mon_v;
  int          mon_c;

  longint m_y, m_x1;
  int     exp_clip;

  alphamission_snd_post dut (
    .clk        (clk),
    .rst        (rst),
    .snd_in     (snd_in),
    .sample_in  (sample_in),
    .gain       (gain),
    .mute       (mute),
    .snd_l      (snd_l),
    .snd_r      (snd_r),
    .sample_out (sample_out),
    .busy       (busy),
    .clip_cnt   (clip_cnt)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  // scoreboard: every sample_out pops one expected value and its cycle
  always @(negedge clk) begin
    if (sample_out) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out: sample_out at cycle %0d with snd_l=%0d, required no output", cyc, snd_l);
      end else begin
        mon_v = exp_q.pop_front();
        mon_c = exp_cyc_q.pop_front();
        if (snd_l !== mon_v) begin
          errors++;
          $display("FAIL out_l: snd_l=%0d, required %0d (cycle %0d)", snd_l, $signed(mon_v), cyc);
        end
        checks++;
        if (snd_r !== mon_v) begin
          errors++;
          $display("FAIL out_r: snd_r=%0d, required %0d (cycle %0d)", snd_r, $signed(mon_v), cyc);
        end
        checks++;
        if (cyc !== mon_c) begin
          errors++;
          $display("FAIL latency: sample_out at cycle %0d, required cycle %0d", cyc, mon_c);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_y = 0;
    m_x1 = 0;
    exp_clip = 0;
  endtask

  task automatic model_sample(input logic signed [15:0] x, input logic [7:0] g, input logic m,
                              output logic [15:0] r);
    longint f, p, q;
    int gi;
`ifdef ALPHAMISSION_SND_DCBLOCK_EN
    m_y = (longint'(x) - m_x1) * 256 + m_y - (m_y >>> 8);
    m_x1 = longint'(x);
    f = m_y >>> 8;
    if (f > 32767) f = 32767;
    if (f < -32768) f = -32768;
`else
    f = longint'(x);
`endif
    gi = int'(g);
    p = f * gi;
    q = p >>> 6;
    if (m) begin
      r = 16'h0000;
    end else if (q > 32767) begin
      r = 16'h7fff;
      if (exp_clip < 255) exp_clip++;
    end else if (q < -32768) begin
      r = 16'h8000;
      if (exp_clip < 255) exp_clip++;
    end else begin
      r = q[15:0];
    end
  endtask

  // call at posedge+1; holds sample_in for one cycle; lat is the required strobe-to-output distance
  task automatic send(input logic signed [15:0] x, input logic [7:0] g, input logic m,
                      input int lat, input bit keep);
    logic [15:0] r;
    snd_in = x;
    gain = g;
    mute = m;
    sample_in = 1'b1;
    if (keep) begin
      model_sample(x, g, m, r);
      exp_q.push_back(r);
      exp_cyc_q.push_back(cyc + lat);
      last_exp = r;
    end
    step();
    sample_in = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || busy) begin
      errors++;
      $display("FAIL %s_drain: %0d outputs outstanding busy=%0b, required 0 and 0", name, exp_q.size(), busy);
      exp_q.delete();
      exp_cyc_q.delete();
    end
    checks++;
    if (clip_cnt !== exp_clip[7:0]) begin
      errors++;
      $display("FAIL %s_clip: clip_cnt=%0d, required %0d", name, clip_cnt, exp_clip);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    model_reset();
    exp_q.delete();
    exp_cyc_q.delete();
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    snd_in = '0;
    sample_in = 1'b0;
    gain = GAIN_UNITY;
    mute = 1'b0;
    model_reset();
    repeat (3) step();
    checks++; if (snd_l !== 16'sd0) begin errors++; $display("FAIL reset_l: snd_l=%0d, required 0", snd_l); end
    checks++; if (snd_r !== 16'sd0) begin errors++; $display("FAIL reset_r: snd_r=%0d, required 0", snd_r); end
    checks++; if (sample_out !== 1'b0) begin errors++; $display("FAIL reset_strobe: sample_out=%0b, required 0", sample_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: busy=%0b, required 0", busy); end
    checks++; if (clip_cnt !== 8'd0) begin errors++; $display("FAIL reset_clip: clip_cnt=%0d, required 0", clip_cnt); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_unity();
    send(16'sd1000, GAIN_UNITY, 1'b0, 4, 1'b1);
    wait_drain("unity");
`ifndef ALPHAMISSION_SND_DCBLOCK_EN
    checks++;
    if (snd_l !== 16'sd1000) begin errors++; $display("FAIL unity_1000: snd_l=%0d, required 1000", snd_l); end
`endif
    repeat (6) begin
      send(16'($signed($urandom_range(0, 32000)) - 16000), 8'($urandom_range(0, 255)), 1'b0, 4, 1'b1);
      repeat (4) step();
    end
    wait_drain("random");
    repeat (5) step();
    checks++;
    if (snd_l !== last_exp) begin errors++; $display("FAIL hold: snd_l=%0d, required held %0d", snd_l, $signed(last_exp)); end
  endtask

`ifdef ALPHAMISSION_SND_DCBLOCK_EN
  task automatic test_dcblock();
    apply_reset();
    send(16'sd1000, GAIN_UNITY, 1'b0, 4, 1'b1);
    wait_drain("dcb_first");
    checks++;
    if (snd_l !== 16'sd1000) begin errors++; $display("FAIL dcb_first: snd_l=%0d, required 1000", snd_l); end
    send(16'sd1000, GAIN_UNITY, 1'b0, 4, 1'b1);
    wait_drain("dcb_second");
    checks++;
    if (snd_l !== 16'sd996) begin errors++; $display("FAIL dcb_second: snd_l=%0d, required 996", snd_l); end
    repeat (8) begin
      send(16'sd1000, GAIN_UNITY, 1'b0, 4, 1'b1);
      repeat (4) step();
    end
    wait_drain("dcb_decay");
  endtask
`endif

  task automatic test_saturation();
    send(16'sd20000, 8'hFF, 1'b0, 4, 1'b1);
    wait_drain("sat_pos");
`ifndef ALPHAMISSION_SND_DCBLOCK_EN
    checks++;
    if (snd_l !== 16'sh7fff) begin errors++; $display("FAIL sat_pos_val: snd_l=%0d, required 32767", snd_l); end
`endif
    send(-16'sd20000, 8'hFF, 1'b0, 4, 1'b1);
    wait_drain("sat_neg");
`ifndef ALPHAMISSION_SND_DCBLOCK_EN
    checks++;
    if (snd_l !== 16'sh8000) begin errors++; $display("FAIL sat_neg_val: snd_l=%0d, required -32768", snd_l); end
`endif
  endtask

  task automatic test_mute();
    send(16'sd32767, 8'hFF, 1'b1, 4, 1'b1);
    wait_drain("mute");
    checks++;
    if (snd_l !== 16'sd0) begin errors++; $display("FAIL mute_val: snd_l=%0d, required 0", snd_l); end
    send(16'sd12345, 8'h00, 1'b0, 4, 1'b1);
    wait_drain("gain_zero");
  endtask

  task automatic test_gain_hold();
    send(16'sd3000, GAIN_UNITY, 1'b0, 4, 1'b1);
    gain = 8'hFF;
    mute = 1'b1;
    wait_drain("gain_hold");
    mute = 1'b0;
  endtask

  task automatic test_busy();
    send(16'sd100, GAIN_UNITY, 1'b0, 4, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL busy_hi: busy=%0b at N+%0d, required 1", busy, k); end
      step();
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL busy_lo: busy=%0b at N+5, required 0", busy); end
    wait_drain("busy");
  endtask

  task automatic test_back_to_back();
    send(16'sd1111, GAIN_UNITY, 1'b0, 4, 1'b1);
    step();
    send(16'sd2222, GAIN_UNITY, 1'b0, 7, 1'b1);
    wait_drain("pend_two");
    send(16'sd3333, GAIN_UNITY, 1'b0, 4, 1'b1);
    step();
    send(16'sd4444, GAIN_UNITY, 1'b0, 0, 1'b0);
    send(-16'sd5555, 8'h80, 1'b0, 6, 1'b1);
    wait_drain("pend_overwrite");
    send(16'sd600, GAIN_UNITY, 1'b0, 4, 1'b1);
    repeat (3) step();
    send(-16'sd700, GAIN_UNITY, 1'b0, 5, 1'b1);
    wait_drain("pend_at_out");
    repeat (2) begin
      send(16'($signed($urandom_range(0, 20000)) - 10000), GAIN_UNITY, 1'b0, 4, 1'b1);
      repeat (4) step();
    end
    wait_drain("max_rate");
  endtask

  task automatic test_clip_limit();
    repeat (260) begin
      send(16'sd30000, 8'hFF, 1'b0, 4, 1'b1);
      repeat (4) step();
    end
    wait_drain("clip_limit");
    checks++;
    if (clip_cnt !== 8'hFF) begin errors++; $display("FAIL clip_sat: clip_cnt=%0d, required 255", clip_cnt); end
  endtask

  task automatic test_reset_mid();
    send(16'sd1234, GAIN_UNITY, 1'b0, 4, 1'b1);
    wait_drain("pre_mid_reset");
    send(16'sd500, GAIN_UNITY, 1'b0, 0, 1'b0);
    step();
    rst = 1'b1;
    #1;
    checks++; if (snd_l !== 16'sd0) begin errors++; $display("FAIL mid_reset_l: snd_l=%0d, required 0", snd_l); end
    checks++; if (snd_r !== 16'sd0) begin errors++; $display("FAIL mid_reset_r: snd_r=%0d, required 0", snd_r); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy: busy=%0b, required 0", busy); end
    checks++; if (sample_out !== 1'b0) begin errors++; $display("FAIL mid_reset_strobe: sample_out=%0b, required 0", sample_out); end
    checks++; if (clip_cnt !== 8'd0) begin errors++; $display("FAIL mid_reset_clip: clip_cnt=%0d, required 0", clip_cnt); end
    model_reset();
    step();
    step();
    rst = 1'b0;
    repeat (6) step();
    send(16'sd777, GAIN_UNITY, 1'b0, 4, 1'b1);
    wait_drain("post_reset");
  endtask

  initial begin
    test_reset();
`ifdef ALPHAMISSION_SND_DCBLOCK_EN
    test_dcblock();
`endif
    test_unity();
    test_saturation();
    test_mute();
    test_gain_hold();
    test_busy();
    test_back_to_back();
    test_clip_limit();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
